// File: rtl/sr_latch_pkg.sv
// Shared definitions for the sr_latch cells: forbidden-input response
// encodings, the per-cell state payload and the forbidden-state resolver.
package sr_pkg;

  localparam int unsigned FORBID_NOR = 32'd0;
  localparam int unsigned FORBID_SET = 32'd1;
  localparam int unsigned FORBID_RST = 32'd2;

  // Registered state of one SR cell; q and qn are stored independently so
  // the NOR-style forbidden state (both low) is representable.
  typedef struct packed {
    logic q;
    logic qn;
    logic illegal;
  } cell_state_t;

  localparam cell_state_t CELL_CLEAR = '{q: 1'b0, qn: 1'b1, illegal: 1'b0};
  localparam cell_state_t CELL_SET   = '{q: 1'b1, qn: 1'b0, illegal: 1'b0};

  // Cell state produced by set=rst=1; unknown modes fall back to NOR.
  function automatic cell_state_t forbid_state(input int unsigned mode);
    cell_state_t s;
    s = '{q: 1'b0, qn: 1'b0, illegal: 1'b1};
    if (mode == FORBID_SET) begin
      s.q  = 1'b1;
      s.qn = 1'b0;
    end else if (mode == FORBID_RST) begin
      s.q  = 1'b0;
      s.qn = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/sr_latch_cell.sv
// sr_cell: one registered set/reset cell.
// Ports: clk, reset (sync, active high), set, rst (functional inputs),
//        q, q_ (true/complement outputs), illegal (last sampled set=rst=1).
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned FORBID_MODE = FORBID_NOR
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic rst,
  output logic q,
  output logic q_,
  output logic illegal
);

  cell_state_t state_r;
  cell_state_t state_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CELL_CLEAR;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode from the sampled {set, rst} pair.
  always_comb begin
    state_nxt         = state_r;
    state_nxt.illegal = 1'b0;
    unique case ({set, rst})
      2'b10: state_nxt = CELL_SET;
      2'b01: state_nxt = CELL_CLEAR;
      2'b11: state_nxt = forbid_state(FORBID_MODE);
      default: begin
        // Release from the both-equal state resolves to clear instead of racing.
        if (state_r.q == state_r.qn) begin
          state_nxt = CELL_CLEAR;
        end
      end
    endcase
  end

  assign q       = state_r.q;
  assign q_      = state_r.qn;
  assign illegal = state_r.illegal;

endmodule

// File: rtl/sr_latch.sv
// sr_latch: WIDTH independent clocked SR latch cells.
// Ports: clk, reset (sync, active high), set/rst (per-cell requests),
//        q/q_ (per-cell true/complement), illegal (per-cell forbidden flag).
module sr_latch
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned FORBID_MODE = FORBID_NOR
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] rst,
  output logic [WIDTH-1:0] illegal
);

  // One cell per bit; no cross-bit interaction.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    sr_cell #(
      .FORBID_MODE(FORBID_MODE)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .set    (set[i]),
      .rst    (rst[i]),
      .q      (q[i]),
      .q_     (q_[i]),
      .illegal(illegal[i])
    );
  end

endmodule

// File: tb/tb_sr_latch.sv
module tb_sr_latch;

  localparam int unsigned W = 4;
  localparam int unsigned NM = 4;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] set, rst;

  logic [W-1:0] q_m [NM];
  logic [W-1:0] qn_m [NM];
  logic [W-1:0] ill_m [NM];
  logic q1, qn1, ill1;

  int total = 0;
  int bad = 0;

  // Reference state per mode and bit
  logic [W-1:0] eq [NM];
  logic [W-1:0] eqn [NM];
  logic [W-1:0] eill [NM];

  always #5 clk = ~clk;

  sr_latch #(.WIDTH(W), .FORBID_MODE(0)) u_m0 (.clk(clk), .reset(reset), .q(q_m[0]), .q_(qn_m[0]),
    .set(set), .rst(rst), .illegal(ill_m[0]));
  sr_latch #(.WIDTH(W), .FORBID_MODE(1)) u_m1 (.clk(clk), .reset(reset), .q(q_m[1]), .q_(qn_m[1]),
    .set(set), .rst(rst), .illegal(ill_m[1]));
  sr_latch #(.WIDTH(W), .FORBID_MODE(2)) u_m2 (.clk(clk), .reset(reset), .q(q_m[2]), .q_(qn_m[2]),
    .set(set), .rst(rst), .illegal(ill_m[2]));
  sr_latch #(.WIDTH(W), .FORBID_MODE(3)) u_m3 (.clk(clk), .reset(reset), .q(q_m[3]), .q_(qn_m[3]),
    .set(set), .rst(rst), .illegal(ill_m[3]));
  sr_latch u_w1 (.clk(clk), .reset(reset), .q(q1), .q_(qn1),
    .set(set[0:0]), .rst(rst[0:0]), .illegal(ill1));

  // Behavioural SR cell: returns {q, qn, illegal}
  function automatic logic [2:0] ref_next(input logic q, input logic qn, input logic s,
                                          input logic r, input int mode, input logic rs);
    if (rs) return 3'b010;
    if (s && !r) return 3'b100;
    if (!s && r) return 3'b010;
    if (!s && !r) return (q == qn) ? 3'b010 : {q, qn, 1'b0};
    if (mode == 1) return 3'b101;
    if (mode == 2) return 3'b011;
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < int'(NM); m++) begin
      check($sformatf("q_mode%0d", m), q_m[m], eq[m]);
      check($sformatf("qn_mode%0d", m), qn_m[m], eqn[m]);
      check($sformatf("illegal_mode%0d", m), ill_m[m], eill[m]);
    end
    check("q_w1", {3'b000, q1}, {3'b000, eq[0][0]});
    check("qn_w1", {3'b000, qn1}, {3'b000, eqn[0][0]});
    check("illegal_w1", {3'b000, ill1}, {3'b000, eill[0][0]});
  endtask

  // Advance one edge with the currently driven inputs, update model, check
  task automatic tick();
    logic [2:0] n;
    @(posedge clk);
    for (int m = 0; m < int'(NM); m++) begin
      for (int b = 0; b < int'(W); b++) begin
        n = ref_next(eq[m][b], eqn[m][b], set[b], rst[b], m, reset);
        eq[m][b] = n[2];
        eqn[m][b] = n[1];
        eill[m][b] = n[0];
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic rs, input logic [W-1:0] s, input logic [W-1:0] r);
    reset = rs;
    set = s;
    rst = r;
  endtask

  initial begin
    reset = 1'b1;
    set = '0;
    rst = '0;
    for (int m = 0; m < int'(NM); m++) begin
      eq[m] = 'x;
      eqn[m] = 'x;
      eill[m] = 'x;
    end

    // Reset for two cycles
    drive(1'b1, 4'b0000, 4'b0000); tick(); tick();
    check("reset_q_const", q_m[0], 4'b0000);
    check("reset_qn_const", qn_m[0], 4'b1111);

    // Set then hold five cycles
    drive(1'b0, 4'b1111, 4'b0000); tick();
    drive(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) tick();
    check("hold_q_const", q_m[0], 4'b1111);

    // Forbidden, drop set, drop rst
    drive(1'b0, 4'b1111, 4'b1111); tick();
    check("forbid_nor_q", q_m[0], 4'b0000);
    check("forbid_nor_qn", qn_m[0], 4'b0000);
    check("forbid_ill", ill_m[0], 4'b1111);
    drive(1'b0, 4'b0000, 4'b1111); tick();
    drive(1'b0, 4'b0000, 4'b0000); tick(); tick();

    // Forbidden to simultaneous release
    drive(1'b0, 4'b1111, 4'b1111); tick();
    drive(1'b0, 4'b0000, 4'b0000); tick();
    check("release_qn_const", qn_m[0], 4'b1111);
    check("release_set_mode_q", q_m[1], 4'b1111);
    check("release_rst_mode_qn", qn_m[2], 4'b1111);
    tick();

    // 11 -> 10 release path
    drive(1'b0, 4'b1111, 4'b1111); tick();
    drive(1'b0, 4'b1111, 4'b0000); tick();

    // Per-bit independence, then reset mid-sequence
    drive(1'b1, 4'b0000, 4'b0000); tick();
    drive(1'b0, 4'b0101, 4'b0011); tick();
    check("indep_q_const", q_m[0], 4'b0100);
    check("indep_qn_const", qn_m[0], 4'b1010);
    check("indep_ill_const", ill_m[0], 4'b0001);
    drive(1'b1, 4'b0101, 4'b0011); tick();
    check("midreset_qn_const", qn_m[0], 4'b1111);
    drive(1'b0, 4'b0000, 4'b0000); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
